// File: rtl/hb_ifc_mem_xcel_pkg.sv
// Shared constants and types for the HammerBlade memory-copy accelerator.
// CSR indices, master request types, engine states and the load-tag marker bit.
package hb_ifc_mem_xcel_pkg;

    // CSR word indices (slave_addr[2:0])
    localparam logic [2:0] CSR_CTRL = 3'd0;
    localparam logic [2:0] CSR_SRC  = 3'd1;
    localparam logic [2:0] CSR_DST  = 3'd2;
    localparam logic [2:0] CSR_SIZE = 3'd3;
    localparam logic [2:0] CSR_SUM  = 3'd4;

    // Master request types
    localparam logic MTYPE_LOAD  = 1'b0;
    localparam logic MTYPE_STORE = 1'b1;

    // Bit of the opaque tag that marks a load issued by this engine
    localparam int LOAD_TAG_BIT = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LD   = 2'd1,
        WT   = 2'd2,
        ST   = 2'd3
    } eng_state_e;

endpackage

// File: rtl/hb_ifc_mem_xcel_csr.sv
// Slave-side CSR block: accepts every request in the cycle it is presented,
// holds SRC/DST/SIZE, and returns a registered read/ack response one cycle later.
// The byte mask and the upper address bits are intentionally unused.
module hb_ifc_mem_xcel_csr
    import hb_ifc_mem_xcel_pkg::*;
#(
    parameter int data_width_p = 32,
    parameter int addr_width_p = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [addr_width_p-1:0] slave_addr,
    input  logic [data_width_p-1:0] slave_data,
    input  logic [3:0]              slave_mask,
    input  logic                    slave_type,
    input  logic                    slave_val,
    output logic                    slave_yum,
    output logic [data_width_p-1:0] slave_ret_data,
    output logic                    slave_ret_val,
    input  logic                    busy,
    input  logic                    done,
    input  logic [data_width_p-1:0] sum,
    output logic                    go,
    output logic [addr_width_p-1:0] src,
    output logic [addr_width_p-1:0] dst,
    output logic [data_width_p-1:0] size
);

    logic [2:0]              idx;
    logic                    wr_en;
    logic [data_width_p-1:0] rd_data;
    logic [data_width_p-1:0] ret_data_p1;
    logic                    ret_vld_p1;
    logic                    unused_slave_bits;

    assign idx               = slave_addr[2:0];
    assign wr_en             = slave_val && slave_type;
    assign slave_yum         = slave_val;
    assign go                = wr_en && (idx == CSR_CTRL) && slave_data[0];
    assign unused_slave_bits = ^{slave_mask, slave_addr[addr_width_p-1:3]};

    // Configuration registers; writes land only while the engine is idle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src  <= '0;
            dst  <= '0;
            size <= '0;
        end else if (wr_en && !busy) begin
            case (idx)
                CSR_SRC:  src  <= slave_data[addr_width_p-1:0];
                CSR_DST:  dst  <= slave_data[addr_width_p-1:0];
                CSR_SIZE: size <= slave_data;
                default:  ;
            endcase
        end
    end

    // Read mux over the current CSR values; unmapped indices read zero.
    always_comb begin
        rd_data = '0;
        case (idx)
            CSR_CTRL: rd_data = {{(data_width_p-2){1'b0}}, done, busy};
            CSR_SRC:  rd_data = data_width_p'(src);
            CSR_DST:  rd_data = data_width_p'(dst);
            CSR_SIZE: rd_data = size;
            CSR_SUM:  rd_data = sum;
            default:  rd_data = '0;
        endcase
    end

    // One-cycle response register: read data for loads, zero for write acks.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ret_vld_p1  <= 1'b0;
            ret_data_p1 <= '0;
        end else begin
            ret_vld_p1  <= slave_val;
            ret_data_p1 <= (slave_val && !slave_type) ? rd_data : '0;
        end
    end

    assign slave_ret_val  = ret_vld_p1;
    assign slave_ret_data = ret_data_p1;

endmodule

// File: rtl/hb_ifc_mem_xcel.sv
// HammerBlade memory-copy accelerator core: CSR slave plus a word-copy engine
// that loads SRC+4i, waits for the tagged response, and stores it to DST+4i.
// Optional feature macro: HB_XCEL_CHECKSUM_EN adds the SUM accumulator (CSR 4);
// without it CSR 4 reads zero and copy behaviour is identical.
module hb_ifc_mem_xcel
    import hb_ifc_mem_xcel_pkg::*;
#(
    parameter int data_width_p    = 32,
    parameter int addr_width_p    = 32,
    parameter int load_id_width_p = 11
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [addr_width_p-1:0]    slave_addr,
    input  logic [data_width_p-1:0]    slave_data,
    input  logic [3:0]                 slave_mask,
    input  logic                       slave_type,
    input  logic                       slave_val,
    output logic                       slave_yum,
    output logic [data_width_p-1:0]    slave_ret_data,
    output logic                       slave_ret_val,
    output logic                       master_val,
    output logic                       master_type,
    output logic [addr_width_p-1:0]    master_addr,
    output logic [load_id_width_p-1:0] master_opq,
    output logic [data_width_p-1:0]    master_data,
    output logic [3:0]                 master_mask,
    input  logic                       master_rdy,
    input  logic [data_width_p-1:0]    master_ret_data,
    input  logic [load_id_width_p-1:0] master_ret_opq,
    input  logic                       master_ret_val
);

    logic                       go;
    logic [addr_width_p-1:0]    src;
    logic [addr_width_p-1:0]    dst;
    logic [data_width_p-1:0]    size;
    logic [data_width_p-1:0]    sum_q;
    logic                       busy;
    logic                       resp_hit;

    eng_state_e                 state_q, state_n;
    logic [data_width_p-1:0]    idx_q, idx_n, idx_inc;
    logic                       done_q, done_n;
    logic                       mval_q, mval_n;
    logic                       mtype_q, mtype_n;
    logic [addr_width_p-1:0]    maddr_q, maddr_n;
    logic [load_id_width_p-1:0] mopq_q, mopq_n;
    logic [data_width_p-1:0]    mdata_q, mdata_n;

    // Load tag: marker bit set, low bits carry the word index.
    function automatic logic [load_id_width_p-1:0] load_tag(input logic [data_width_p-1:0] idx);
        logic [load_id_width_p-1:0] tag;
        tag                      = '0;
        tag[LOAD_TAG_BIT-1:0]    = idx[LOAD_TAG_BIT-1:0];
        tag[LOAD_TAG_BIT]        = 1'b1;
        return tag;
    endfunction

    // Byte address of word idx from base; wraps modulo the address width.
    function automatic logic [addr_width_p-1:0] word_addr(input logic [addr_width_p-1:0] base,
                                                          input logic [data_width_p-1:0] idx);
        return base + addr_width_p'({idx, 2'b00});
    endfunction

    assign busy     = (state_q != IDLE);
    assign idx_inc  = idx_q + 1'b1;
    // Store acks never match: every issued tag has the marker bit set.
    assign resp_hit = master_ret_val && (master_ret_opq == mopq_q);

    hb_ifc_mem_xcel_csr #(
        .data_width_p (data_width_p),
        .addr_width_p (addr_width_p)
    ) u_csr (
        .clk            (clk),
        .reset_n        (reset_n),
        .slave_addr     (slave_addr),
        .slave_data     (slave_data),
        .slave_mask     (slave_mask),
        .slave_type     (slave_type),
        .slave_val      (slave_val),
        .slave_yum      (slave_yum),
        .slave_ret_data (slave_ret_data),
        .slave_ret_val  (slave_ret_val),
        .busy           (busy),
        .done           (done_q),
        .sum            (sum_q),
        .go             (go),
        .src            (src),
        .dst            (dst),
        .size           (size)
    );

    // Engine state, word index, done flag and the registered master request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            done_q  <= 1'b0;
            mval_q  <= 1'b0;
            mtype_q <= MTYPE_LOAD;
            maddr_q <= '0;
            mopq_q  <= '0;
            mdata_q <= '0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            done_q  <= done_n;
            mval_q  <= mval_n;
            mtype_q <= mtype_n;
            maddr_q <= maddr_n;
            mopq_q  <= mopq_n;
            mdata_q <= mdata_n;
        end
    end

    // Copy FSM: next state and the next master request, computed on each transition
    // so the request fields stay frozen while the master side stalls.
    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        done_n  = done_q;
        mval_n  = mval_q;
        mtype_n = mtype_q;
        maddr_n = maddr_q;
        mopq_n  = mopq_q;
        mdata_n = mdata_q;
        case (state_q)
            IDLE: begin
                if (go) begin
                    idx_n = '0;
                    if (size == '0) begin
                        done_n = 1'b1;
                    end else begin
                        done_n  = 1'b0;
                        state_n = LD;
                        mval_n  = 1'b1;
                        mtype_n = MTYPE_LOAD;
                        maddr_n = src;
                        mopq_n  = load_tag('0);
                        mdata_n = '0;
                    end
                end
            end
            LD: begin
                if (master_rdy) begin
                    state_n = WT;
                    mval_n  = 1'b0;
                end
            end
            WT: begin
                if (resp_hit) begin
                    state_n = ST;
                    mval_n  = 1'b1;
                    mtype_n = MTYPE_STORE;
                    maddr_n = word_addr(dst, idx_q);
                    mdata_n = master_ret_data;
                end
            end
            ST: begin
                if (master_rdy) begin
                    idx_n = idx_inc;
                    if (idx_inc == size) begin
                        state_n = IDLE;
                        mval_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        state_n = LD;
                        mval_n  = 1'b1;
                        mtype_n = MTYPE_LOAD;
                        maddr_n = word_addr(src, idx_inc);
                        mopq_n  = load_tag(idx_inc);
                        mdata_n = '0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef HB_XCEL_CHECKSUM_EN
    // Checksum of every accepted load word; a GO in idle restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q <= '0;
        end else if ((state_q == IDLE) && go) begin
            sum_q <= '0;
        end else if ((state_q == WT) && resp_hit) begin
            sum_q <= sum_q + master_ret_data;
        end
    end
`else
    assign sum_q = '0;
`endif

    assign master_val  = mval_q;
    assign master_type = mtype_q;
    assign master_addr = maddr_q;
    assign master_opq  = mopq_q;
    assign master_data = mdata_q;
    assign master_mask = 4'hF;

endmodule

// File: tb/tb_hb_ifc_mem_xcel.sv
// Testbench for hb_ifc_mem_xcel: CSR vector table, directed copy sequences,
// and randomized copies checked against a word-level reference model.
`timescale 1ns/1ps
module tb_hb_ifc_mem_xcel;

    logic        clk;
    logic        reset_n;
    logic [31:0] slave_addr;
    logic [31:0] slave_data;
    logic [3:0]  slave_mask;
    logic        slave_type;
    logic        slave_val;
    logic        slave_yum;
    logic [31:0] slave_ret_data;
    logic        slave_ret_val;
    logic        master_val;
    logic        master_type;
    logic [31:0] master_addr;
    logic [10:0] master_opq;
    logic [31:0] master_data;
    logic [3:0]  master_mask;
    logic        master_rdy;
    logic [31:0] master_ret_data;
    logic [10:0] master_ret_opq;
    logic        master_ret_val;

    hb_ifc_mem_xcel dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .slave_addr      (slave_addr),
        .slave_data      (slave_data),
        .slave_mask      (slave_mask),
        .slave_type      (slave_type),
        .slave_val       (slave_val),
        .slave_yum       (slave_yum),
        .slave_ret_data  (slave_ret_data),
        .slave_ret_val   (slave_ret_val),
        .master_val      (master_val),
        .master_type     (master_type),
        .master_addr     (master_addr),
        .master_opq      (master_opq),
        .master_data     (master_data),
        .master_mask     (master_mask),
        .master_rdy      (master_rdy),
        .master_ret_data (master_ret_data),
        .master_ret_opq  (master_ret_opq),
        .master_ret_val  (master_ret_val)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        string       name;
    } csr_vec_t;

    typedef struct {
        logic        typ;
        logic [31:0] addr;
        logic [10:0] opq;
        logic [31:0] data;
        logic [3:0]  mask;
    } mreq_t;

    typedef struct {
        logic [10:0] opq;
        logic [31:0] data;
    } junk_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Test-owned knobs read by the memory responder
    int    rdy_mode   = 0;   // 0: always ready, 1: random, 2: never ready
    bit    rand_delay = 0;
    bit    junk_en    = 0;
    bit    hold       = 0;
    junk_t junk_q[$];

    // Responder-owned state
    mreq_t       log_q[$];
    int          junk_rd = 0;
    bit          pend_valid = 0;
    int          pend_delay = 0;
    logic [10:0] pend_opq;
    logic [31:0] pend_addr;
    bit          stall_prev = 0;
    logic [31:0] sv_addr;
    logic [31:0] sv_data;
    logic [10:0] sv_opq;
    logic        sv_type;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Memory contents: words 5,7,9 at 0x1000.., a hash of the address elsewhere
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a >= 32'h1000 && a < 32'h100C) return 32'd5 + 32'd2 * ((a - 32'h1000) >> 2);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // Memory responder: drives master_rdy, logs handshakes, answers loads
    initial begin
        master_rdy      = 1'b0;
        master_ret_val  = 1'b0;
        master_ret_opq  = '0;
        master_ret_data = '0;
        forever begin
            @(negedge clk);
            if (stall_prev && reset_n) begin
                chk("stall_addr_stable", master_addr, sv_addr);
                chk("stall_opq_stable", {21'd0, master_opq}, {21'd0, sv_opq});
                chk("stall_type_stable", {31'd0, master_type}, {31'd0, sv_type});
                chk("stall_data_stable", master_data, sv_data);
            end
            master_ret_val = 1'b0;
            if (pend_valid && !hold) begin
                if (pend_delay == 0) begin
                    master_ret_val  = 1'b1;
                    master_ret_opq  = pend_opq;
                    master_ret_data = mem_word(pend_addr);
                    pend_valid      = 0;
                end else begin
                    pend_delay--;
                end
            end
            if (!master_ret_val && junk_rd < junk_q.size()) begin
                master_ret_val  = 1'b1;
                master_ret_opq  = junk_q[junk_rd].opq;
                master_ret_data = junk_q[junk_rd].data;
                junk_rd++;
            end else if (!master_ret_val && junk_en && $urandom_range(0, 3) == 0) begin
                logic [10:0] j;
                j = 11'($urandom);
                if (pend_valid && j[0]) j = pend_opq ^ 11'(1 << $urandom_range(0, 9));
                else j[10] = 1'b0;
                master_ret_val  = 1'b1;
                master_ret_opq  = j;
                master_ret_data = $urandom;
            end
            case (rdy_mode)
                0:       master_rdy = 1'b1;
                1:       master_rdy = 1'($urandom_range(0, 1));
                default: master_rdy = 1'b0;
            endcase
            if (reset_n && master_val && master_rdy) begin
                log_q.push_back('{master_type, master_addr, master_opq, master_data, master_mask});
                if (master_type == 1'b0) begin
                    pend_valid = 1;
                    pend_opq   = master_opq;
                    pend_addr  = master_addr;
                    pend_delay = rand_delay ? $urandom_range(0, 3) : 0;
                end
            end
            stall_prev = reset_n && master_val && !master_rdy;
            sv_addr    = master_addr;
            sv_data    = master_data;
            sv_opq     = master_opq;
            sv_type    = master_type;
        end
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic csr(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       output logic [31:0] rdata);
        @(negedge clk);
        slave_val  = 1'b1;
        slave_type = wr;
        slave_addr = addr;
        slave_data = data;
        slave_mask = 4'($urandom);
        #1;
        chk("slave_yum", {31'd0, slave_yum}, 32'd1);
        @(posedge clk);
        #1;
        slave_val = 1'b0;
        @(negedge clk);
        chk("slave_ret_val", {31'd0, slave_ret_val}, 32'd1);
        rdata = slave_ret_data;
        if (wr) chk("write_ack_data", rdata, 32'd0);
    endtask

    task automatic csr_expect(input string name, input logic [31:0] idx, input logic [31:0] exp);
        logic [31:0] r;
        csr(1'b0, idx, 32'd0, r);
        chk(name, r, exp);
    endtask

    task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [31:0] n);
        logic [31:0] r;
        csr(1'b1, 32'd1, s, r);
        csr(1'b1, 32'd2, d, r);
        csr(1'b1, 32'd3, n, r);
        csr(1'b1, 32'd0, 32'd1, r);
    endtask

    task automatic wait_done();
        logic [31:0] st;
        bit ok;
        ok = 0;
        for (int n = 0; n < 2000; n++) begin
            csr(1'b0, 32'd0, 32'd0, st);
            if (st == 32'd2) begin
                ok = 1;
                break;
            end
        end
        chk("done_within_budget", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_load(input int base);
        int n;
        n = 0;
        while (log_q.size() <= base && n < 200) begin
            @(negedge clk);
            n++;
        end
        #2;
        chk("load_issued_within_budget", 32'(log_q.size() > base), 32'd1);
    endtask

    // Reference model: word k is loaded from s+4k with tag {1,k} and stored to d+4k
    task automatic check_copy(input int base, input logic [31:0] s, input logic [31:0] d,
                              input int n);
        logic [31:0] sum, exp_sum;
        sum = 32'd0;
        chk("request_count", 32'(log_q.size() - base), 32'(2 * n));
        for (int k = 0; k < n; k++) begin
            logic [31:0] sa, da, w, kk;
            mreq_t ld, st;
            kk  = 32'(k);
            sa  = s + 32'(4 * k);
            da  = d + 32'(4 * k);
            w   = mem_word(sa);
            sum = sum + w;
            if (base + 2 * k + 1 < log_q.size()) begin
                ld = log_q[base + 2 * k];
                st = log_q[base + 2 * k + 1];
                chk("load_type", {31'd0, ld.typ}, 32'd0);
                chk("load_addr", ld.addr, sa);
                chk("load_opq", {21'd0, ld.opq}, {21'd0, 1'b1, kk[9:0]});
                chk("load_data_zero", ld.data, 32'd0);
                chk("load_mask", {28'd0, ld.mask}, 32'hF);
                chk("store_type", {31'd0, st.typ}, 32'd1);
                chk("store_addr", st.addr, da);
                chk("store_data", st.data, w);
                chk("store_mask", {28'd0, st.mask}, 32'hF);
            end
        end
`ifdef HB_XCEL_CHECKSUM_EN
        exp_sum = sum;
`else
        exp_sum = 32'd0;
`endif
        csr_expect("status_done", 32'd0, 32'd2);
        csr_expect("sum", 32'd4, exp_sum);
    endtask

    initial begin
        csr_vec_t    vecs[$];
        logic [31:0] r;
        int          base;

        reset_n    = 1'b0;
        slave_val  = 1'b0;
        slave_type = 1'b0;
        slave_addr = '0;
        slave_data = '0;
        slave_mask = '0;
        repeat (3) @(negedge clk);
        chk("rst_master_val", {31'd0, master_val}, 32'd0);
        chk("rst_master_type", {31'd0, master_type}, 32'd0);
        chk("rst_master_addr", master_addr, 32'd0);
        chk("rst_master_opq", {21'd0, master_opq}, 32'd0);
        chk("rst_master_data", master_data, 32'd0);
        chk("rst_master_mask", {28'd0, master_mask}, 32'hF);
        chk("rst_slave_ret_val", {31'd0, slave_ret_val}, 32'd0);
        chk("rst_slave_ret_data", slave_ret_data, 32'd0);
        chk("idle_slave_yum", {31'd0, slave_yum}, 32'd0);
        reset_n = 1'b1;

        // CSR round-trip vectors
        vecs.push_back('{1'b0, 32'd0, 32'd0,        32'd0,      "rst_status"});
        vecs.push_back('{1'b0, 32'd1, 32'd0,        32'd0,      "rst_src"});
        vecs.push_back('{1'b0, 32'd4, 32'd0,        32'd0,      "rst_sum"});
        vecs.push_back('{1'b1, 32'd1, 32'h1000,     32'd0,      "wr_src"});
        vecs.push_back('{1'b0, 32'd1, 32'd0,        32'h1000,   "rd_src"});
        vecs.push_back('{1'b1, 32'd2, 32'h2000,     32'd0,      "wr_dst"});
        vecs.push_back('{1'b0, 32'd2, 32'd0,        32'h2000,   "rd_dst"});
        vecs.push_back('{1'b1, 32'd3, 32'd5,        32'd0,      "wr_size"});
        vecs.push_back('{1'b0, 32'd3, 32'd0,        32'd5,      "rd_size"});
        vecs.push_back('{1'b1, 32'd5, 32'hDEAD,     32'd0,      "wr_idx5"});
        vecs.push_back('{1'b0, 32'd5, 32'd0,        32'd0,      "rd_idx5"});
        vecs.push_back('{1'b0, 32'd7, 32'd0,        32'd0,      "rd_idx7"});
        vecs.push_back('{1'b1, 32'd4, 32'h1234,     32'd0,      "wr_sum_ro"});
        vecs.push_back('{1'b0, 32'd4, 32'd0,        32'd0,      "rd_sum_ro"});
        vecs.push_back('{1'b1, 32'd0, 32'd0,        32'd0,      "wr_ctrl_nogo"});
        vecs.push_back('{1'b0, 32'd0, 32'd0,        32'd0,      "rd_status_idle"});
        vecs.push_back('{1'b0, 32'h0000_0009, 32'd0, 32'h1000, "rd_src_alias"});
        vecs.push_back('{1'b1, 32'd3, 32'd0,        32'd0,      "wr_size0"});
        vecs.push_back('{1'b0, 32'd3, 32'd0,        32'd0,      "rd_size0"});
        for (int v = 0; v < vecs.size(); v++) begin
            csr(vecs[v].wr, vecs[v].addr, vecs[v].wdata, r);
            chk(vecs[v].name, r, vecs[v].exp);
        end
        @(negedge clk);
        chk("ret_val_single_pulse", {31'd0, slave_ret_val}, 32'd0);
        chk("no_master_traffic_idle", 32'(log_q.size()), 32'd0);

        // Directed copy: 3 words 5,7,9 from 0x1000 to 0x2000
        rdy_mode = 0; rand_delay = 0; junk_en = 0;
        base = log_q.size();
        start_copy(32'h1000, 32'h2000, 32'd3);
        wait_done();
        check_copy(base, 32'h1000, 32'h2000, 3);

        // Back-pressure in LD: request frozen, no advance
        rdy_mode = 2;
        base = log_q.size();
        start_copy(32'h3000, 32'h4000, 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            chk("bp_val", {31'd0, master_val}, 32'd1);
            chk("bp_addr", master_addr, 32'h3000);
            chk("bp_opq", {21'd0, master_opq}, 32'h400);
            chk("bp_type", {31'd0, master_type}, 32'd0);
        end
        csr_expect("bp_status_busy", 32'd0, 32'd1);
        chk("bp_no_handshake", 32'(log_q.size() - base), 32'd0);
        rdy_mode = 0;
        wait_done();
        check_copy(base, 32'h3000, 32'h4000, 1);

        // Store ack and wrong tag during WT are ignored
        hold = 1;
        base = log_q.size();
        start_copy(32'h5000, 32'h6000, 32'd1);
        wait_load(base);
        junk_q.push_back('{11'h000, 32'h55});
        junk_q.push_back('{11'h401, 32'h66});
        repeat (5) @(negedge clk);
        #1;
        chk("wt_ignores_bad_resp", {31'd0, master_val}, 32'd0);
        chk("wt_no_store_yet", 32'(log_q.size() - base), 32'd1);
        csr_expect("wt_status_busy", 32'd0, 32'd1);
        hold = 0;
        wait_done();
        check_copy(base, 32'h5000, 32'h6000, 1);

        // Writes to SRC/SIZE and GO while busy are ignored
        rdy_mode = 1; rand_delay = 1; junk_en = 1;
        base = log_q.size();
        start_copy(32'h9000, 32'hA000, 32'd2);
        csr(1'b1, 32'd1, 32'hBBB0, r);
        csr(1'b1, 32'd3, 32'd7, r);
        csr(1'b1, 32'd0, 32'd1, r);
        wait_done();
        check_copy(base, 32'h9000, 32'hA000, 2);
        csr_expect("busy_src_ignored", 32'd1, 32'h9000);
        csr_expect("busy_size_ignored", 32'd3, 32'd2);

        // SIZE=0 GO: done at once, no requests, SUM cleared
        rdy_mode = 0; junk_en = 0; rand_delay = 0;
        base = log_q.size();
        csr(1'b1, 32'd3, 32'd0, r);
        csr(1'b1, 32'd0, 32'd1, r);
        csr_expect("size0_status", 32'd0, 32'd2);
        csr_expect("size0_sum_cleared", 32'd4, 32'd0);
        chk("size0_no_requests", 32'(log_q.size() - base), 32'd0);

        // Randomized copies against the reference model
        rdy_mode = 1; rand_delay = 1; junk_en = 1;
        for (int it = 0; it < 6; it++) begin
            logic [31:0] s, d, n;
            s = (it == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            d = (it == 1) ? 32'hFFFF_FFFC : $urandom;
            n = 32'($urandom_range(1, 12));
            base = log_q.size();
            start_copy(s, d, n);
            wait_done();
            check_copy(base, s, d, int'(n));
            csr_expect("rand_src_readback", 32'd1, s);
            csr_expect("rand_dst_readback", 32'd2, d);
            csr_expect("rand_size_readback", 32'd3, n);
        end

        // Asynchronous reset mid-WT; the late response must be ignored
        rdy_mode = 0; rand_delay = 0; junk_en = 0; hold = 1;
        base = log_q.size();
        start_copy(32'h7000, 32'h8000, 32'd2);
        wait_load(base);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_master_val", {31'd0, master_val}, 32'd0);
        chk("async_rst_master_addr", master_addr, 32'd0);
        chk("async_rst_master_opq", {21'd0, master_opq}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        hold = 0;
        repeat (6) @(negedge clk);
        #1;
        chk("late_resp_ignored_val", {31'd0, master_val}, 32'd0);
        chk("late_resp_no_store", 32'(log_q.size() - base), 32'd1);
        for (int i = 0; i < 5; i++) csr_expect("post_rst_csr_zero", 32'(i), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hb_ifc_mem_xcel.md
# hb_ifc_mem_xcel

Memory-copy accelerator tile core for the HammerBlade manycore. It sits behind the manycore endpoint, with two sides:
- **Slave side:** a CSR block that the host or cores configure with remote stores and loads.
- **Master side:** an engine that issues word load/store requests through the packet encoder.

On GO it copies N 32-bit words from a source byte address to a destination byte address. It also accumulates a 32-bit checksum of the copied data.

## Interface
Parameters:
- `data_width_p`, 32, data/CSR width.
- `addr_width_p`, 32, slave and master address width.
- `load_id_width_p`, 11, opaque tag width.

Ports (clock and reset first):
- `clk` input 1: clock. One clock; reset is asynchronous and active-low.
- `reset_n` input 1: asynchronous active-low reset.
- `slave_addr` input 32: CSR word index; bits [2:0] are used.
- `slave_data` input 32: write data.
- `slave_mask` input 4: byte mask; ignored, so writes are full-word.
- `slave_type` input 1: 1 = write, 0 = read.
- `slave_val` input 1: request valid.
- `slave_yum` output 1: request consumed this cycle.
- `slave_ret_data` output 32: read/ack data.
- `slave_ret_val` output 1: response valid.
- `master_val` output 1: memory request valid.
- `master_type` output 1: 1 = store, 0 = load.
- `master_addr` output 32: byte address.
- `master_opq` output 11: load tag.
- `master_data` output 32: store data; 0 for loads.
- `master_mask` output 4: always 4'hF.
- `master_rdy` input 1: request accepted when `master_val`&`master_rdy`.
- `master_ret_data` input 32: response data.
- `master_ret_opq` input 11: response tag.
- `master_ret_val` input 1: response valid; always accepted, no back-pressure.

## Operation
CSRs (index = `slave_addr[2:0]`):
- 0 CTRL/STATUS. Write bit0=1 = GO. Read = {30'b0, done, busy}.
- 1 SRC. Byte base address.
- 2 DST. Byte base address.
- 3 SIZE. Word count.
- 4 SUM. Checksum, read-only.
- 5–7: read 0; writes ignored.

CSR rules:
- Writes to SRC/DST/SIZE while busy are ignored. GO while busy is ignored.
- GO in idle clears `done`, clears SUM and index i, and sets busy.

Engine states:
- IDLE: wait for GO. If SIZE==0, set done and stay IDLE.
- LD: `master_val`=1, type=0, addr=SRC+4·i, opq={1'b1, i[9:0]}. On `master_rdy` go to WT.
- WT: wait for `master_ret_val` with `master_ret_opq`==issued tag. Latch the data and add it to SUM (mod 2^32). Go to ST.
- ST: `master_val`=1, type=1, addr=DST+4·i, data=latched word. On `master_rdy`: i++. If i==SIZE go to IDLE with done=1, busy=0; else go to LD.

Additional rules:
- Responses with `master_ret_opq[10]`==0 (store acks), or responses outside WT, are ignored.
- Address arithmetic wraps modulo 2^32.

## Timing
- `slave_yum` = `slave_val`, combinational. Every request is accepted in the cycle it is presented.
- `slave_ret_val` pulses exactly one cycle after each `slave_yum`, for reads and writes.
  - Read: `slave_ret_data` = CSR value sampled at yum.
  - Write: `slave_ret_data` = 0.
- A CSR written in cycle t is visible to a read in cycle t+1.
- Master fields are registered and held stable while `master_val`=1 and `master_rdy`=0.
- At most one load is outstanding.
- Best case per word: LD 1 cycle, WT ≥1 cycle, ST 1 cycle.
- Response in the same cycle as load acceptance is impossible; the WT check starts the cycle after LD handshake.
- A GO write and a done transition in the same cycle: done wins, and the GO is ignored as busy.
- Reset (async, any time) values:
  - All CSRs = 0, state IDLE, i=0.
  - Outputs `slave_yum`=`slave_val`-driven, `slave_ret_val`=0, `slave_ret_data`=0.
  - `master_val`=0, `master_type`=0, `master_addr`=0, `master_opq`=0, `master_data`=0, `master_mask`=4'hF.
  - An in-flight copy is abandoned; late responses after reset are ignored.

## Configuration
- `HB_XCEL_CHECKSUM_EN` defined: SUM accumulator present and readable at CSR 4.
- Not defined: no accumulator logic; CSR 4 reads 0. Copy behaviour is unchanged.

## Structure
- Package `hb_ifc_mem_xcel_pkg`:
  - CSR index localparams (CTRL=0, SRC=1, DST=2, SIZE=3, SUM=4).
  - Master type constants (LOAD=0, STORE=1).
  - Engine state enum {IDLE, LD, WT, ST}.
  - Load-tag marker bit position (10).
- One sub-module `hb_ifc_mem_xcel_csr`: slave handshake, CSR storage, and the one-cycle read-response register. The top level holds the copy FSM.

## Test plan
- CSR round-trip: write SRC=0x1000, read index 1 → `slave_ret_val` next cycle with data 0x1000; write returns data 0.
- Copy SIZE=3, SRC=0x1000 (words 5,7,9), DST=0x2000, `master_rdy`=1:
  - Requests: L 0x1000 opq 0x400, S 0x2000 d5, L 0x1004 opq 0x401, S 0x2004 d7, L 0x1008, S 0x2008 d9.
  - STATUS reads 2 (done); SUM reads 21 (0 without `HB_XCEL_CHECKSUM_EN`).
- Back-pressure: hold `master_rdy`=0 for 5 cycles in LD → addr/opq/type stable, no advance.
- Ignored responses: inject a store ack (opq 0x000) and a mismatched tag during WT → FSM stays in WT until the correct tag arrives.
- SIZE=0 GO → no `master_val`, STATUS=2 next cycle. GO/SRC write while busy → ignored.
- Assert `reset_n`=0 mid-WT → `master_val`=0 immediately, all CSRs read 0 after release.
